// File: rtl/rle_stream_encoder.sv
// Run-length encoder for activation / feature-map streams.
// Merges consecutive equal symbols into (value, length) records with a
// saturating length field, valid/ready on both sides, and frame close on
// in_last. With ZERO_ONLY set, only runs of zero are merged.
module rle_stream_encoder #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned LEN_W     = 8,
  parameter int unsigned ZERO_ONLY = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_value,
  output logic [LEN_W-1:0]  out_len,
  output logic              out_last
);

  localparam logic [LEN_W-1:0] MAX_LEN = '1;
  localparam logic [LEN_W-1:0] ONE_LEN = LEN_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_LAST_PEND
  } state_t;

  // Run accumulator and FSM state
  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_cur_val;
  logic [DATA_W-1:0]   w_cur_val_nxt;
  logic [LEN_W-1:0]    r_cur_len;
  logic [LEN_W-1:0]    w_cur_len_nxt;

  // Single-entry output register
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_value;
  logic [LEN_W-1:0]    r_out_len;
  logic                r_out_last;

  // Output-register load request from the next-state logic
  logic                w_load;
  logic [DATA_W-1:0]   w_ld_value;
  logic [LEN_W-1:0]    w_ld_len;
  logic                w_ld_last;

  logic                w_out_free;
  logic                w_accept;
  logic                w_same;
  logic                w_room;
  logic                w_mergeable;
  logic                w_extend;

  // The output register can take a new record when empty or draining now
  assign w_out_free  = !r_out_valid || out_ready;
  assign in_ready    = rst_n && (r_state != S_LAST_PEND) && w_out_free;
  assign w_accept    = in_valid && in_ready;

  assign w_same      = (in_data == r_cur_val);
  assign w_room      = (r_cur_len < MAX_LEN);
  assign w_mergeable = (ZERO_ONLY == 0) || (r_cur_val == '0);
  assign w_extend    = (r_state == S_RUN) && w_same && w_room && w_mergeable;

  // Next-state, accumulator update and output-register load selection
  always_comb begin
    w_state_nxt   = r_state;
    w_cur_val_nxt = r_cur_val;
    w_cur_len_nxt = r_cur_len;
    w_load        = 1'b0;
    w_ld_value    = r_cur_val;
    w_ld_len      = r_cur_len;
    w_ld_last     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (in_last) begin
            // Single-symbol frame: emit directly, nothing stays open
            w_load        = 1'b1;
            w_ld_value    = in_data;
            w_ld_len      = ONE_LEN;
            w_ld_last     = 1'b1;
            w_cur_val_nxt = in_data;
            w_cur_len_nxt = '0;
            w_state_nxt   = S_IDLE;
          end else begin
            w_cur_val_nxt = in_data;
            w_cur_len_nxt = ONE_LEN;
            w_state_nxt   = S_RUN;
          end
        end
      end

      S_RUN: begin
        if (w_accept) begin
          if (w_extend) begin
            if (in_last) begin
              w_load        = 1'b1;
              w_ld_value    = r_cur_val;
              w_ld_len      = r_cur_len + ONE_LEN;
              w_ld_last     = 1'b1;
              w_cur_len_nxt = '0;
              w_state_nxt   = S_IDLE;
            end else begin
              w_cur_len_nxt = r_cur_len + ONE_LEN;
            end
          end else begin
            // Break: close the current run, restart with the new symbol.
            // A break on the final symbol leaves a second record pending.
            w_load        = 1'b1;
            w_ld_value    = r_cur_val;
            w_ld_len      = r_cur_len;
            w_ld_last     = 1'b0;
            w_cur_val_nxt = in_data;
            w_cur_len_nxt = ONE_LEN;
            w_state_nxt   = in_last ? S_LAST_PEND : S_RUN;
          end
        end
      end

      S_LAST_PEND: begin
        if (w_out_free) begin
          w_load        = 1'b1;
          w_ld_value    = r_cur_val;
          w_ld_len      = r_cur_len;
          w_ld_last     = 1'b1;
          w_cur_len_nxt = '0;
          w_state_nxt   = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM state and run accumulator registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cur_val <= '0;
      r_cur_len <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cur_val <= w_cur_val_nxt;
      r_cur_len <= w_cur_len_nxt;
    end
  end

  // Output register: load takes priority over drain so a same-cycle
  // drain-and-load keeps the new record; fields hold while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_value <= '0;
      r_out_len   <= '0;
      r_out_last  <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_value <= w_ld_value;
      r_out_len   <= w_ld_len;
      r_out_last  <= w_ld_last;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_value = r_out_value;
  assign out_len   = r_out_len;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_rle_stream_encoder.sv
// Directed bench for rle_stream_encoder: three instances cover the default
// configuration, a 4-bit length field and zero-only mode. Expected records
// go into per-instance queues and are checked as the DUT hands them over.
module tb_rle_stream_encoder;

  logic        clk;
  logic        rst_n;
  logic        iv   [3];
  logic        il   [3];
  logic [7:0]  id   [3];
  logic [2:0]  ordy;

  wire  [2:0]  ir;
  wire  [2:0]  ov;
  wire  [2:0]  olast;
  wire  [7:0]  oval0, oval1, oval2;
  wire  [7:0]  olen0, olen2;
  wire  [3:0]  olen1;

  int          total;
  int          bad;

  logic [16:0] q0 [$];
  logic [16:0] q1 [$];
  logic [16:0] q2 [$];

  logic [16:0] held [3];
  bit          hv   [3];
  logic [16:0] mon_cur;
  logic [16:0] mon_exp;

  bit          use_model;
  bit          m_open;
  logic [7:0]  m_val;
  int          m_len;

  rle_stream_encoder #(.DATA_W(8), .LEN_W(8), .ZERO_ONLY(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]), .in_last(il[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_value(oval0),
    .out_len(olen0), .out_last(olast[0])
  );

  rle_stream_encoder #(.DATA_W(8), .LEN_W(4), .ZERO_ONLY(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]), .in_last(il[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_value(oval1),
    .out_len(olen1), .out_last(olast[1])
  );

  rle_stream_encoder #(.DATA_W(8), .LEN_W(8), .ZERO_ONLY(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]), .in_last(il[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_value(oval2),
    .out_len(olen2), .out_last(olast[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] val_of(input int k);
    case (k)
      0:       return oval0;
      1:       return oval1;
      default: return oval2;
    endcase
  endfunction

  function automatic logic [7:0] len_of(input int k);
    case (k)
      0:       return olen0;
      1:       return {4'b0000, olen1};
      default: return olen2;
    endcase
  endfunction

  function automatic int qsize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [16:0] qpop(input int k);
    case (k)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic expect_rec(input int k, input logic [7:0] v, input logic [7:0] n, input logic l);
    case (k)
      0:       q0.push_back({v, n, l});
      1:       q1.push_back({v, n, l});
      default: q2.push_back({v, n, l});
    endcase
  endtask

  // Reference RLE for the default configuration (MAX_LEN = 255)
  task automatic model_accept(input logic [7:0] d, input logic l);
    if (!m_open) begin
      m_val  = d;
      m_len  = 1;
      m_open = 1'b1;
    end else if (d == m_val && m_len < 255) begin
      m_len++;
    end else begin
      expect_rec(0, m_val, 8'(m_len), 1'b0);
      m_val = d;
      m_len = 1;
    end
    if (l) begin
      expect_rec(0, m_val, 8'(m_len), 1'b1);
      m_open = 1'b0;
    end
  endtask

  // Present one symbol and hold it until accepted (bounded)
  task automatic send(input int k, input logic [7:0] d, input logic l, output int waits);
    @(negedge clk);
    iv[k] = 1'b1;
    id[k] = d;
    il[k] = l;
    #1;
    waits = 0;
    while (ir[k] !== 1'b1 && waits < 100) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (waits >= 100) chk("accept_timeout", 32'(ir[k]), 32'd1);
    @(posedge clk);
    if (use_model && k == 0) model_accept(d, l);
  endtask

  task automatic idle(input int k);
    @(negedge clk);
    iv[k] = 1'b0;
    il[k] = 1'b0;
  endtask

  task automatic drain_wait(input int budget);
    for (int c = 0; c < budget && (q0.size() + q1.size() + q2.size()) != 0; c++)
      @(negedge clk);
  endtask

  // Output monitor: compares handshakes against the queues and checks
  // that a stalled record stays valid and unchanged
  always begin
    @(negedge clk);
    #3;
    for (int k = 0; k < 3; k++) begin
      mon_cur = {val_of(k), len_of(k), olast[k]};
      if (!rst_n) begin
        hv[k] = 1'b0;
      end else begin
        if (hv[k]) begin
          chk("held_valid", 32'(ov[k]), 32'd1);
          if (ov[k]) chk("held_stable", 32'(mon_cur), 32'(held[k]));
        end
        if (ov[k] && ordy[k]) begin
          chk("record_expected", 32'(qsize(k) != 0), 32'd1);
          if (qsize(k) != 0) begin
            mon_exp = qpop(k);
            chk($sformatf("record_dut%0d", k), 32'(mon_cur), 32'(mon_exp));
          end
          hv[k] = 1'b0;
        end else if (ov[k]) begin
          hv[k]   = 1'b1;
          held[k] = mon_cur;
        end else begin
          hv[k] = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    int w;
    int wsum;
    total     = 0;
    bad       = 0;
    use_model = 1'b0;
    m_open    = 1'b0;
    m_val     = '0;
    m_len     = 0;
    rst_n     = 1'b0;
    ordy      = 3'b111;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0;
      il[k] = 1'b0;
      id[k] = '0;
      hv[k] = 1'b0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", 32'(ir), 32'd0);
    chk("rst_out_valid", 32'(ov), 32'd0);
    chk("rst_out_last", 32'(olast), 32'd0);
    chk("rst_out_value", 32'({oval0, oval1, oval2}), 32'd0);
    chk("rst_out_len", 32'({olen0, olen1, olen2}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_reset", 32'(ir), 32'h7);

    // First symbol after reset is 0: no merge with reset cur_val
    expect_rec(0, 8'd0, 8'd2, 1'b1);
    send(0, 8'd0, 1'b0, w);
    send(0, 8'd0, 1'b1, w);
    idle(0);
    drain_wait(20);

    // 5,5,5,7,7,9(last): full throughput, then one LAST_PEND stall cycle
    expect_rec(0, 8'd5, 8'd3, 1'b0);
    expect_rec(0, 8'd7, 8'd2, 1'b0);
    expect_rec(0, 8'd9, 8'd1, 1'b1);
    wsum = 0;
    send(0, 8'd5, 1'b0, w); wsum += w;
    send(0, 8'd5, 1'b0, w); wsum += w;
    send(0, 8'd5, 1'b0, w); wsum += w;
    send(0, 8'd7, 1'b0, w); wsum += w;
    send(0, 8'd7, 1'b0, w); wsum += w;
    send(0, 8'd9, 1'b1, w); wsum += w;
    chk("throughput_waits", 32'(wsum), 32'd0);
    @(negedge clk);
    iv[0] = 1'b0;
    il[0] = 1'b0;
    #1;
    chk("last_pend_stall", 32'(ir[0]), 32'd0);
    @(negedge clk);
    #1;
    chk("last_pend_release", 32'(ir[0]), 32'd1);
    drain_wait(20);

    // LEN_W=4 saturation: twenty 0xAA -> (AA,15,0), (AA,5,1)
    expect_rec(1, 8'hAA, 8'd15, 1'b0);
    expect_rec(1, 8'hAA, 8'd5, 1'b1);
    for (int i = 0; i < 20; i++) send(1, 8'hAA, (i == 19), w);
    idle(1);
    drain_wait(20);

    // ZERO_ONLY: 0,0,0,3,3,0(last)
    expect_rec(2, 8'd0, 8'd3, 1'b0);
    expect_rec(2, 8'd3, 8'd1, 1'b0);
    expect_rec(2, 8'd3, 8'd1, 1'b0);
    expect_rec(2, 8'd0, 8'd1, 1'b1);
    send(2, 8'd0, 1'b0, w);
    send(2, 8'd0, 1'b0, w);
    send(2, 8'd0, 1'b0, w);
    send(2, 8'd3, 1'b0, w);
    send(2, 8'd3, 1'b0, w);
    send(2, 8'd0, 1'b1, w);
    idle(2);
    drain_wait(20);

    // Backpressure: out_ready low for 10 cycles while breaking runs arrive
    use_model = 1'b1;
    @(negedge clk);
    ordy[0] = 1'b0;
    fork
      begin
        int wb;
        send(0, 8'd1, 1'b0, wb);
        send(0, 8'd2, 1'b0, wb);
        send(0, 8'd2, 1'b0, wb);
        send(0, 8'd3, 1'b0, wb);
        send(0, 8'd4, 1'b0, wb);
        send(0, 8'd4, 1'b0, wb);
        send(0, 8'd5, 1'b0, wb);
        send(0, 8'd5, 1'b0, wb);
        send(0, 8'd5, 1'b0, wb);
        send(0, 8'd6, 1'b1, wb);
        idle(0);
      end
      begin
        repeat (10) @(negedge clk);
        chk("bp_in_ready_low", 32'(ir[0]), 32'd0);
        chk("bp_out_valid_high", 32'(ov[0]), 32'd1);
        ordy[0] = 1'b1;
      end
    join
    use_model = 1'b0;
    drain_wait(40);
    chk("bp_queue_empty", 32'(q0.size()), 32'd0);

    // Reset mid-frame with a record pending: everything discarded
    @(negedge clk);
    ordy[0] = 1'b0;
    send(0, 8'd6, 1'b0, w);
    send(0, 8'd6, 1'b0, w);
    send(0, 8'd6, 1'b0, w);
    send(0, 8'd6, 1'b0, w);
    send(0, 8'd8, 1'b0, w);
    @(negedge clk);
    iv[0] = 1'b0;
    #1;
    chk("pre_reset_valid", 32'(ov[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_out_valid", 32'(ov[0]), 32'd0);
    chk("mid_reset_in_ready", 32'(ir[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    ordy[0] = 1'b1;
    m_open  = 1'b0;
    expect_rec(0, 8'd2, 8'd1, 1'b1);
    send(0, 8'd2, 1'b1, w);
    idle(0);

    drain_wait(50);
    repeat (3) @(negedge clk);
    chk("final_q0_empty", 32'(q0.size()), 32'd0);
    chk("final_q1_empty", 32'(q1.size()), 32'd0);
    chk("final_q2_empty", 32'(q2.size()), 32'd0);
    chk("final_out_valid", 32'(ov), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
